// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Address map, access-size encodings and byte-merge helper shared
//             by the load-store unit and its data memory.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Address map (bits [31:16] must be zero for any mapped access)
    localparam logic [31:0] DMEM_BASE   = 32'h0000_2000;
    localparam logic [31:0] LEDR_ADDR   = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR   = 32'h0000_7010;
    localparam logic [31:0] HEX_LO_ADDR = 32'h0000_7020;
    localparam logic [31:0] HEX_HI_ADDR = 32'h0000_7024;
    localparam logic [31:0] LCD_ADDR    = 32'h0000_7030;
    localparam logic [31:0] SW_ADDR     = 32'h0000_7800;
    localparam logic [31:0] BTN_ADDR    = 32'h0000_7810;

    // Access-size encodings carried on the mask input
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Core-side request/response and board I/O bundle of the LSU.
//             master = core/board side, slave = the LSU itself.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_if;
    import lsu_pkg::*;

    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [3:0]  i_mask;
    logic        i_mem_un;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] o_ld_data;
    logic        o_misalign;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [6:0]  o_io_hex0;
    logic [6:0]  o_io_hex1;
    logic [6:0]  o_io_hex2;
    logic [6:0]  o_io_hex3;
    logic [6:0]  o_io_hex4;
    logic [6:0]  o_io_hex5;
    logic [6:0]  o_io_hex6;
    logic [6:0]  o_io_hex7;
    logic [31:0] o_io_lcd;

    modport master (
        output i_lsu_addr, i_st_data, i_lsu_wren, i_mask, i_mem_un,
        output i_io_sw, i_io_btn,
        input  o_ld_data, o_misalign, o_io_ledr, o_io_ledg,
        input  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3,
        input  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7,
        input  o_io_lcd
    );

    modport slave (
        input  i_lsu_addr, i_st_data, i_lsu_wren, i_mask, i_mem_un,
        input  i_io_sw, i_io_btn,
        output o_ld_data, o_misalign, o_io_ledr, o_io_ledg,
        output o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3,
        output o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7,
        output o_io_lcd
    );

endinterface
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dmem
//  Purpose  : Data memory, synchronous byte-enabled write and asynchronous
//             read on a single word index. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 8192
) (
    input  wire logic                            i_clk,
    input  wire logic                            i_we,
    input  wire logic [3:0]                      i_be,
    input  wire logic [$clog2(DMEM_BYTES)-3:0]   i_widx,
    input  wire logic [31:0]                     i_wdata,
    output      logic [31:0]                     o_rdata
);

    localparam int c_depth = DMEM_BYTES / 4;

    logic [31:0] r_mem [c_depth];

    // Byte-lane write on the clock edge; disabled lanes keep their contents
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read is combinational so loads complete in the same cycle
    assign o_rdata = r_mem[i_widx];

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load-store unit of the single-cycle RV32I core. Decodes the
//             address map, lane-shifts store data, extends load data, and owns
//             the data memory, the board output registers and the input
//             synchronizers.
//  Revision : 1.0  initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 8192
) (
    input  wire logic i_clk,
    input  wire logic i_reset,
    lsu_if.slave      bus
);

    localparam int          c_dmem_aw    = $clog2(DMEM_BYTES);
    localparam logic [13:0] c_dmem_limit = 14'(DMEM_BYTES);

    logic        w_mask_legal;
    logic        w_misalign;
    logic        w_hit_dmem;
    logic        w_hit_ledr;
    logic        w_hit_ledg;
    logic        w_hit_hex_lo;
    logic        w_hit_hex_hi;
    logic        w_hit_lcd;
    logic        w_hit_sw;
    logic        w_hit_btn;
    logic [4:0]  w_lane_shift;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_st_ok;
    logic        w_dmem_we;
    logic [31:0] w_dmem_rdata;
    logic [31:0] w_word;
    logic [31:0] w_lane;
    logic [31:0] w_ld;

    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hex_lo;
    logic [31:0] r_hex_hi;
    logic [31:0] r_lcd;
    logic [31:0] r_sw_meta;
    logic [31:0] r_sw_sync;
    logic [3:0]  r_btn_meta;
    logic [3:0]  r_btn_sync;

    // Address decode, alignment check and store lane placement
    always_comb begin
        w_mask_legal = (bus.i_mask == MASK_B) || (bus.i_mask == MASK_H) ||
                       (bus.i_mask == MASK_W);
        w_misalign   = ((bus.i_mask == MASK_H) && bus.i_lsu_addr[0]) ||
                       ((bus.i_mask == MASK_W) && (bus.i_lsu_addr[1:0] != 2'b00));

        // Register comparisons span bits [31:2], so nonzero upper bits miss
        w_hit_dmem   = (bus.i_lsu_addr[31:13] == DMEM_BASE[31:13]) &&
                       ({1'b0, bus.i_lsu_addr[12:0]} < c_dmem_limit);
        w_hit_ledr   = (bus.i_lsu_addr[31:2] == LEDR_ADDR[31:2]);
        w_hit_ledg   = (bus.i_lsu_addr[31:2] == LEDG_ADDR[31:2]);
        w_hit_hex_lo = (bus.i_lsu_addr[31:2] == HEX_LO_ADDR[31:2]);
        w_hit_hex_hi = (bus.i_lsu_addr[31:2] == HEX_HI_ADDR[31:2]);
        w_hit_lcd    = (bus.i_lsu_addr[31:2] == LCD_ADDR[31:2]);
        w_hit_sw     = (bus.i_lsu_addr[31:2] == SW_ADDR[31:2]);
        w_hit_btn    = (bus.i_lsu_addr[31:2] == BTN_ADDR[31:2]);

        w_lane_shift = {bus.i_lsu_addr[1:0], 3'b000};
        w_be         = bus.i_mask << bus.i_lsu_addr[1:0];
        w_wdata      = bus.i_st_data << w_lane_shift;

        // A store coincident with reset is discarded everywhere
        w_st_ok      = bus.i_lsu_wren && w_mask_legal && !w_misalign && !i_reset;
        w_dmem_we    = w_st_ok && w_hit_dmem;
    end

    lsu_dmem #(
        .DMEM_BYTES (DMEM_BYTES)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_we    (w_dmem_we),
        .i_be    (w_be),
        .i_widx  (bus.i_lsu_addr[c_dmem_aw-1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_dmem_rdata)
    );

    // Select the addressed word; unmapped addresses read as zero
    always_comb begin
        w_word = 32'h0;
        if (w_hit_dmem) begin
            w_word = w_dmem_rdata;
        end else if (w_hit_ledr) begin
            w_word = r_ledr;
        end else if (w_hit_ledg) begin
            w_word = r_ledg;
        end else if (w_hit_hex_lo) begin
            w_word = r_hex_lo;
        end else if (w_hit_hex_hi) begin
            w_word = r_hex_hi;
        end else if (w_hit_lcd) begin
            w_word = r_lcd;
        end else if (w_hit_sw) begin
            w_word = r_sw_sync;
        end else if (w_hit_btn) begin
            w_word = {28'h0, r_btn_sync};
        end
    end

    // Shift the addressed lane down and sign/zero extend by access size
    always_comb begin
        w_lane = w_word >> w_lane_shift;
        w_ld   = 32'h0;
        if (w_mask_legal && !w_misalign) begin
            case (bus.i_mask)
                MASK_B:  w_ld = bus.i_mem_un ? {24'h0, w_lane[7:0]}
                                             : {{24{w_lane[7]}}, w_lane[7:0]};
                MASK_H:  w_ld = bus.i_mem_un ? {16'h0, w_lane[15:0]}
                                             : {{16{w_lane[15]}}, w_lane[15:0]};
                default: w_ld = w_lane;
            endcase
        end
    end

    // Board output registers, byte-merged on mapped aligned stores
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ledr   <= 32'h0;
            r_ledg   <= 32'h0;
            r_hex_lo <= 32'h0;
            r_hex_hi <= 32'h0;
            r_lcd    <= 32'h0;
        end else if (w_st_ok) begin
            if (w_hit_ledr)   r_ledr   <= merge_bytes(r_ledr,   w_wdata, w_be);
            if (w_hit_ledg)   r_ledg   <= merge_bytes(r_ledg,   w_wdata, w_be);
            if (w_hit_hex_lo) r_hex_lo <= merge_bytes(r_hex_lo, w_wdata, w_be);
            if (w_hit_hex_hi) r_hex_hi <= merge_bytes(r_hex_hi, w_wdata, w_be);
            if (w_hit_lcd)    r_lcd    <= merge_bytes(r_lcd,    w_wdata, w_be);
        end
    end

    // Two-flop synchronizers for the asynchronous switches and buttons
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sw_meta  <= 32'h0;
            r_sw_sync  <= 32'h0;
            r_btn_meta <= 4'h0;
            r_btn_sync <= 4'h0;
        end else begin
            r_sw_meta  <= bus.i_io_sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= bus.i_io_btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    assign bus.o_ld_data  = w_ld;
    assign bus.o_misalign = w_misalign;
    assign bus.o_io_ledr  = r_ledr;
    assign bus.o_io_ledg  = r_ledg;
    assign bus.o_io_lcd   = r_lcd;
    // Bit 7 of each HEX byte is kept for read-back but never drives a segment
    assign bus.o_io_hex0  = r_hex_lo[6:0];
    assign bus.o_io_hex1  = r_hex_lo[14:8];
    assign bus.o_io_hex2  = r_hex_lo[22:16];
    assign bus.o_io_hex3  = r_hex_lo[30:24];
    assign bus.o_io_hex4  = r_hex_hi[6:0];
    assign bus.o_io_hex5  = r_hex_hi[14:8];
    assign bus.o_io_hex6  = r_hex_hi[22:16];
    assign bus.o_io_hex7  = r_hex_hi[30:24];

endmodule
`default_nettype wire
